// File: rtl/systolic_pkg.sv
// Shared systolic-array definitions: FP16 field layout, drain FIFO entry type
// and the stall skid allowance used by the column-end drain.
package systolic_pkg;

    localparam int unsigned FP16_W = 16;
    localparam int unsigned EXP_W  = 5;
    localparam int unsigned MAN_W  = 10;

    localparam logic [EXP_W-1:0] EXP_ALL_ONES = '1;

    // Writes that may still land after o_pipeline_en falls (PE output register).
    localparam int unsigned DRAIN_SKID = 1;

    typedef struct packed {
        logic              last;
        logic [FP16_W-1:0] data;
    } psum_entry_t;

    // Quiet or signalling NaN: exponent all ones, mantissa nonzero.
    function automatic logic is_fp16_nan(input logic [FP16_W-1:0] v);
        return (v[MAN_W +: EXP_W] == EXP_ALL_ONES) && (v[MAN_W-1:0] != '0);
    endfunction

endpackage

// File: rtl/psum_drain_ofbsc_if.sv
// Stream bundle of the column-end drain: partial-sum input from the last FMA
// and the valid/ready output towards write-back.
interface psum_drain_ofbsc_if #(
    parameter int unsigned FP_W = 16
);
    logic            psum_valid;
    logic [FP_W-1:0] psum;
    logic            valid;
    logic            ready;
    logic [FP_W-1:0] data;
    logic            last;

    // Environment side: drives partial sums and downstream ready.
    modport master (
        output psum_valid, psum, ready,
        input  valid, data, last
    );

    // Drain side.
    modport slave (
        input  psum_valid, psum, ready,
        output valid, data, last
    );
endinterface

// File: rtl/psum_drain_fifo.sv
// Drain FIFO: storage, wrapping pointers and occupancy. The caller guarantees
// i_wr/i_rd are already qualified (no write when full without a read, no read
// when empty, neither during flush).
module psum_drain_fifo
    import systolic_pkg::*;
#(
    parameter type         entry_t = psum_entry_t,
    parameter int unsigned DEPTH   = 8,
    localparam int unsigned AW     = $clog2(DEPTH),
    localparam int unsigned OW     = AW + 1
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_flush,
    input  logic          i_wr,
    input  logic          i_rd,
    input  entry_t        i_wdata,
    output entry_t        o_rdata,
    output logic [OW-1:0] o_occ_next,
    output logic          o_full,
    output logic          o_empty
);

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [OW-1:0] occ_q, occ_d;
    entry_t        mem_q [DEPTH];

    // Next pointers and occupancy; flush wins over any access.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        occ_d  = occ_q;
        if (i_flush) begin
            wptr_d = '0;
            rptr_d = '0;
            occ_d  = '0;
        end else begin
            if (i_wr) wptr_d = wptr_q + AW'(1);
            if (i_rd) rptr_d = rptr_q + AW'(1);
            case ({i_wr, i_rd})
                2'b10:   occ_d = occ_q + OW'(1);
                2'b01:   occ_d = occ_q - OW'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    // Pointer and occupancy state.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            occ_q  <= occ_d;
        end
    end

    // Storage array; contents are only observed through the occupancy gate.
    always_ff @(posedge i_clk) begin
        if (i_wr) mem_q[wptr_q] <= i_wdata;
    end

    // Head and status flags.
    always_comb begin
        o_rdata    = mem_q[rptr_q];
        o_occ_next = occ_d;
        o_full     = (occ_q == OW'(DEPTH));
        o_empty    = (occ_q == '0);
    end

endmodule

// File: rtl/psum_drain_ofbsc.sv
// Column-end partial-sum drain: buffers FMA results, tags the last row of each
// tile, streams them out on valid/ready and stalls the array via a registered
// pipeline enable when the buffer nears full.
// Optional NaN detection is built when PSUM_DRAIN_NAN_CHECK_EN is defined.
module psum_drain_ofbsc
    import systolic_pkg::*;
#(
    parameter int unsigned FP_W  = 16,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned ROWS  = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    psum_drain_ofbsc_if.slave    bus,
    input  logic                 i_flush,
    output logic                 o_pipeline_en,
    output logic                 o_overflow
`ifdef PSUM_DRAIN_NAN_CHECK_EN
    ,
    output logic                 o_nan_seen
`endif
);

    localparam int unsigned OW        = $clog2(DEPTH) + 1;
    localparam int unsigned RW        = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned EnThresh  = DEPTH - 1 - DRAIN_SKID;

    typedef struct packed {
        logic            last;
        logic [FP_W-1:0] data;
    } entry_t;

    entry_t        wdata;
    entry_t        head;
    logic [OW-1:0] occ_next;
    logic          fifo_full;
    logic          fifo_empty;
    logic          out_valid;
    logic          wr;
    logic          rd;
    logic          last_tag;

    logic [RW-1:0] row_cnt_q, row_cnt_d;
    logic          pipeline_en_q, pipeline_en_d;
    logic          overflow_q, overflow_d;
`ifdef PSUM_DRAIN_NAN_CHECK_EN
    logic          nan_seen_q, nan_seen_d;
`endif

    psum_drain_fifo #(
        .entry_t (entry_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_flush    (i_flush),
        .i_wr       (wr),
        .i_rd       (rd),
        .i_wdata    (wdata),
        .o_rdata    (head),
        .o_occ_next (occ_next),
        .o_full     (fifo_full),
        .o_empty    (fifo_empty)
    );

    // Handshake qualification; a read in the same cycle frees room at full.
    always_comb begin
        out_valid  = ~fifo_empty;
        rd         = out_valid & bus.ready & ~i_flush;
        wr         = bus.psum_valid & (~fifo_full | rd) & ~i_flush;
        last_tag   = (row_cnt_q == RW'(ROWS - 1));
        wdata.last = last_tag;
        wdata.data = bus.psum;
    end

    // Output stream; data is forced to zero whenever nothing is presented.
    always_comb begin
        bus.valid = out_valid;
        bus.data  = out_valid ? head.data : '0;
        bus.last  = out_valid & head.last;
    end

    // Next state for row counter, stall enable and sticky flags.
    always_comb begin
        row_cnt_d     = row_cnt_q;
        pipeline_en_d = pipeline_en_q;
        overflow_d    = overflow_q;
`ifdef PSUM_DRAIN_NAN_CHECK_EN
        nan_seen_d    = nan_seen_q;
`endif
        if (i_flush) begin
            row_cnt_d     = '0;
            pipeline_en_d = 1'b1;
            overflow_d    = 1'b0;
`ifdef PSUM_DRAIN_NAN_CHECK_EN
            nan_seen_d    = 1'b0;
`endif
        end else begin
            if (wr) row_cnt_d = last_tag ? '0 : row_cnt_q + RW'(1);
            pipeline_en_d = (occ_next <= OW'(EnThresh));
            // A dropped write does not advance row_cnt, so tile tagging resyncs.
            if (bus.psum_valid && fifo_full && !rd) overflow_d = 1'b1;
`ifdef PSUM_DRAIN_NAN_CHECK_EN
            if (wr && is_fp16_nan(FP16_W'(bus.psum))) nan_seen_d = 1'b1;
`endif
        end
    end

    // Control and flag registers.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            row_cnt_q     <= '0;
            pipeline_en_q <= 1'b1;
            overflow_q    <= 1'b0;
`ifdef PSUM_DRAIN_NAN_CHECK_EN
            nan_seen_q    <= 1'b0;
`endif
        end else begin
            row_cnt_q     <= row_cnt_d;
            pipeline_en_q <= pipeline_en_d;
            overflow_q    <= overflow_d;
`ifdef PSUM_DRAIN_NAN_CHECK_EN
            nan_seen_q    <= nan_seen_d;
`endif
        end
    end

    assign o_pipeline_en = pipeline_en_q;
    assign o_overflow    = overflow_q;
`ifdef PSUM_DRAIN_NAN_CHECK_EN
    assign o_nan_seen    = nan_seen_q;
`endif

endmodule

// File: tb/tb_psum_drain_ofbsc.sv
// Scoreboard bench for psum_drain_ofbsc: an independent FIFO/tile model is
// advanced per cycle and compared against the DUT outputs at the falling edge.
// NaN checks are compiled when PSUM_DRAIN_NAN_CHECK_EN is defined.
module tb_psum_drain_ofbsc;

    localparam int unsigned FP_W  = 16;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned ROWS  = 4;

    logic clk   = 1'b0;
    logic rstn  = 1'b0;
    logic flush = 1'b0;
    logic en;
    logic ovf;
`ifdef PSUM_DRAIN_NAN_CHECK_EN
    logic nan;
`endif

    psum_drain_ofbsc_if #(.FP_W(FP_W)) bus ();

    psum_drain_ofbsc #(
        .FP_W  (FP_W),
        .DEPTH (DEPTH),
        .ROWS  (ROWS)
    ) dut (
        .i_clk         (clk),
        .i_rstn        (rstn),
        .bus           (bus),
        .i_flush       (flush),
        .o_pipeline_en (en),
        .o_overflow    (ovf)
`ifdef PSUM_DRAIN_NAN_CHECK_EN
        ,
        .o_nan_seen    (nan)
`endif
    );

    always #5 clk = ~clk;

    int unsigned vecs = 0;
    int unsigned errs = 0;

    // Model state: queued {last, data}, tile row, sticky flags.
    logic [FP_W:0] mq [$];
    int unsigned   m_row = 0;
    logic          m_ovf = 1'b0;
    logic          m_nan = 1'b0;

    function automatic logic [FP_W:0] exp_head();
        return (mq.size() != 0) ? mq[0] : '0;
    endfunction

    function automatic logic exp_en();
        return (mq.size() <= DEPTH - 2);
    endfunction

    // One clock: drive inputs, advance model on the edge, return at negedge.
    task automatic tick(input logic v, input logic [FP_W-1:0] d, input logic rdy,
                        input logic fl);
        logic m_rd, m_wr, m_full;
        bus.psum_valid = v;
        bus.psum       = d;
        bus.ready      = rdy;
        flush          = fl;
        m_full = (mq.size() == DEPTH);
        m_rd   = (mq.size() != 0) && rdy && !fl;
        m_wr   = v && (!m_full || m_rd) && !fl;
        @(posedge clk);
        if (fl) begin
            mq.delete();
            m_row = 0;
            m_ovf = 1'b0;
            m_nan = 1'b0;
        end else begin
            if (m_rd) void'(mq.pop_front());
            if (m_wr) begin
                mq.push_back({(m_row == ROWS - 1), d});
                m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
                if (d[14:10] == 5'h1F && d[9:0] != 10'h0) m_nan = 1'b1;
            end
            if (v && m_full && !m_rd) m_ovf = 1'b1;
        end
        @(negedge clk);
        bus.psum_valid = 1'b0;
        flush          = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        vecs++; if (en !== 1'b1) begin errs++; $display("FAIL reset_en got %b want 1", en); end
        vecs++; if (bus.valid !== 1'b0) begin errs++; $display("FAIL reset_valid got %b want 0", bus.valid); end
        vecs++; if (bus.data !== '0) begin errs++; $display("FAIL reset_data got %h want 0", bus.data); end
        vecs++; if (bus.last !== 1'b0) begin errs++; $display("FAIL reset_last got %b want 0", bus.last); end
        vecs++; if (ovf !== 1'b0) begin errs++; $display("FAIL reset_ovf got %b want 0", ovf); end
`ifdef PSUM_DRAIN_NAN_CHECK_EN
        vecs++; if (nan !== 1'b0) begin errs++; $display("FAIL reset_nan got %b want 0", nan); end
`endif
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [FP_W:0] h;
        int unsigned   lasts = 0;
        for (int i = 0; i < 10; i++) begin
            tick((i < 8), FP_W'(16'h3C00 + i * 16'h0400), 1'b1, 1'b0);
            h = exp_head();
            vecs++; if (bus.valid !== (mq.size() != 0)) begin errs++; $display("FAIL basic_valid cyc %0d got %b want %b", i, bus.valid, (mq.size() != 0)); end
            vecs++; if (bus.data !== h[FP_W-1:0]) begin errs++; $display("FAIL basic_data cyc %0d got %h want %h", i, bus.data, h[FP_W-1:0]); end
            vecs++; if (bus.last !== h[FP_W]) begin errs++; $display("FAIL basic_last cyc %0d got %b want %b", i, bus.last, h[FP_W]); end
            if (bus.valid && bus.last) lasts++;
        end
        vecs++; if (lasts != 2) begin errs++; $display("FAIL basic_last_count got %0d want 2", lasts); end
    endtask

    task automatic test_backpressure();
        logic          en_d1 = 1'b1;
        logic          en_d2 = 1'b1;
        logic [FP_W:0] h;
        // Upstream honours the enable through two register stages.
        for (int i = 0; i < 12; i++) begin
            tick(en_d2, FP_W'(16'h4400 + i), 1'b0, 1'b0);
            en_d2 = en_d1;
            en_d1 = en;
            vecs++; if (en !== exp_en()) begin errs++; $display("FAIL bp_en cyc %0d got %b want %b", i, en, exp_en()); end
            vecs++; if (ovf !== 1'b0) begin errs++; $display("FAIL bp_ovf cyc %0d got %b want 0", i, ovf); end
        end
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, '0, 1'b1, 1'b0);
            h = exp_head();
            vecs++; if (bus.valid !== (mq.size() != 0)) begin errs++; $display("FAIL bp_drain_valid cyc %0d got %b want %b", i, bus.valid, (mq.size() != 0)); end
            vecs++; if (bus.data !== h[FP_W-1:0]) begin errs++; $display("FAIL bp_drain_data cyc %0d got %h want %h", i, bus.data, h[FP_W-1:0]); end
            vecs++; if (en !== exp_en()) begin errs++; $display("FAIL bp_drain_en cyc %0d got %b want %b", i, en, exp_en()); end
        end
    endtask

    task automatic test_overflow();
        logic [FP_W:0] h;
        for (int i = 0; i < 9; i++) begin
            tick(1'b1, FP_W'(16'h5000 + i), 1'b0, 1'b0);
            vecs++; if (ovf !== m_ovf) begin errs++; $display("FAIL ovf_flag cyc %0d got %b want %b", i, ovf, m_ovf); end
        end
        vecs++; if (ovf !== 1'b1) begin errs++; $display("FAIL ovf_set got %b want 1", ovf); end
        // Drain the kept data, then a fresh tile must tag its 4th element.
        for (int i = 0; i < 14; i++) begin
            tick((i >= 8 && i < 12), FP_W'(16'h5400 + i), 1'b1, 1'b0);
            h = exp_head();
            vecs++; if (bus.data !== h[FP_W-1:0]) begin errs++; $display("FAIL ovf_data cyc %0d got %h want %h", i, bus.data, h[FP_W-1:0]); end
            vecs++; if (bus.last !== h[FP_W]) begin errs++; $display("FAIL ovf_last cyc %0d got %b want %b", i, bus.last, h[FP_W]); end
        end
    endtask

    task automatic test_simul_full();
        logic [FP_W:0] h;
        tick(1'b0, '0, 1'b0, 1'b1);
        vecs++; if (ovf !== 1'b0) begin errs++; $display("FAIL sim_flush_ovf got %b want 0", ovf); end
        for (int i = 0; i < 8; i++) tick(1'b1, FP_W'(16'h5800 + i), 1'b0, 1'b0);
        tick(1'b1, 16'h6000, 1'b1, 1'b0);
        h = exp_head();
        vecs++; if (bus.valid !== 1'b1) begin errs++; $display("FAIL sim_valid got %b want 1", bus.valid); end
        vecs++; if (en !== exp_en()) begin errs++; $display("FAIL sim_en got %b want %b", en, exp_en()); end
        vecs++; if (ovf !== 1'b0) begin errs++; $display("FAIL sim_ovf got %b want 0", ovf); end
        vecs++; if (bus.data !== h[FP_W-1:0]) begin errs++; $display("FAIL sim_head got %h want %h", bus.data, h[FP_W-1:0]); end
        for (int i = 0; i < 9; i++) begin
            tick(1'b0, '0, 1'b1, 1'b0);
            h = exp_head();
            vecs++; if (bus.data !== h[FP_W-1:0]) begin errs++; $display("FAIL sim_drain_data cyc %0d got %h want %h", i, bus.data, h[FP_W-1:0]); end
            vecs++; if (bus.last !== h[FP_W]) begin errs++; $display("FAIL sim_drain_last cyc %0d got %b want %b", i, bus.last, h[FP_W]); end
        end
    endtask

    task automatic test_flush_reset();
        for (int i = 0; i < 5; i++) tick(1'b1, FP_W'(16'h6400 + i), 1'b0, 1'b0);
        tick(1'b1, 16'h6800, 1'b1, 1'b1);
        vecs++; if (bus.valid !== 1'b0) begin errs++; $display("FAIL flush_valid got %b want 0", bus.valid); end
        vecs++; if (en !== 1'b1) begin errs++; $display("FAIL flush_en got %b want 1", en); end
        for (int i = 0; i < 9; i++) tick(1'b1, FP_W'(16'h6C00 + i), 1'b0, 1'b0);
        vecs++; if (ovf !== 1'b1) begin errs++; $display("FAIL burst_ovf got %b want 1", ovf); end
        // Asynchronous reset in the middle of a low clock phase.
        bus.psum_valid = 1'b1;
        #2 rstn = 1'b0;
        #1;
        mq.delete();
        m_row = 0;
        m_ovf = 1'b0;
        m_nan = 1'b0;
        vecs++; if (en !== 1'b1) begin errs++; $display("FAIL arst_en got %b want 1", en); end
        vecs++; if (bus.valid !== 1'b0) begin errs++; $display("FAIL arst_valid got %b want 0", bus.valid); end
        vecs++; if (bus.data !== '0) begin errs++; $display("FAIL arst_data got %h want 0", bus.data); end
        vecs++; if (ovf !== 1'b0) begin errs++; $display("FAIL arst_ovf got %b want 0", ovf); end
        bus.psum_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        vecs++; if (bus.valid !== 1'b0) begin errs++; $display("FAIL arst_release_valid got %b want 0", bus.valid); end
    endtask

`ifdef PSUM_DRAIN_NAN_CHECK_EN
    task automatic test_nan();
        tick(1'b1, 16'h7E00, 1'b1, 1'b0);
        vecs++; if (nan !== 1'b1) begin errs++; $display("FAIL nan_set got %b want 1", nan); end
        tick(1'b0, '0, 1'b1, 1'b1);
        vecs++; if (nan !== 1'b0) begin errs++; $display("FAIL nan_flush got %b want 0", nan); end
        tick(1'b1, 16'h7C00, 1'b1, 1'b0);
        tick(1'b0, '0, 1'b1, 1'b0);
        vecs++; if (nan !== m_nan) begin errs++; $display("FAIL nan_inf got %b want %b", nan, m_nan); end
    endtask
`endif

    initial begin
        bus.psum_valid = 1'b0;
        bus.psum       = '0;
        bus.ready      = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_simul_full();
        test_flush_reset();
`ifdef PSUM_DRAIN_NAN_CHECK_EN
        test_nan();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
